// File: rtl/neurotransmitter_level_integrator.sv
// Saturating neurotransmitter level integrator with a hysteretic 2-bit band code.
// Define NT_DECAY_EN to add idle-tick decay of the level back toward BASELINE.
module neurotransmitter_level_integrator #(
    parameter int WIDTH     = 8,
    parameter int BASELINE  = 64,
    parameter int SLOW_STEP = 1,
    parameter int FAST_STEP = 4,
    parameter int HYST      = 8
`ifdef NT_DECAY_EN
    ,
    parameter int DECAY_TICKS = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             inc,
    input  logic             dec,
    input  logic             fast,
    output logic [WIDTH-1:0] level,
    output logic [1:0]       level_q,
    output logic             sat_hi,
    output logic             sat_lo
);

    typedef enum logic [1:0] {B0 = 2'd0, B1 = 2'd1, B2 = 2'd2, B3 = 2'd3} band_t;

    localparam logic [WIDTH-1:0] BASE_W    = WIDTH'(BASELINE);
    localparam logic [WIDTH:0]   MAX_X     = (WIDTH+1)'((1 << WIDTH) - 1);
    localparam logic [WIDTH:0]   SLOW_X    = (WIDTH+1)'(SLOW_STEP);
    localparam logic [WIDTH:0]   FAST_X    = (WIDTH+1)'(FAST_STEP);
    localparam logic [WIDTH:0]   HYST_X    = (WIDTH+1)'(HYST);
    localparam band_t            BAND_RST  = band_t'(2'(BASELINE >> (WIDTH-2)));

    logic [WIDTH-1:0] r_level;
    band_t            r_band;

    logic [WIDTH:0]   w_level_x;
    logic [WIDTH:0]   w_step;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_inc_val;
    logic [WIDTH-1:0] w_dec_val;
    logic             w_do_inc;
    logic             w_do_dec;
    logic [WIDTH:0]   w_up_thr;
    logic [WIDTH:0]   w_dn_thr;
    logic             w_band_up;
    logic             w_band_dn;
    logic             w_decay_step;

    // All arithmetic is one bit wider than the level so saturation never wraps.
    assign w_level_x = {1'b0, r_level};
    assign w_step    = fast ? FAST_X : SLOW_X;
    assign w_sum     = w_level_x + w_step;
    assign w_inc_val = (w_sum > MAX_X) ? MAX_X[WIDTH-1:0] : w_sum[WIDTH-1:0];
    assign w_dec_val = (w_level_x < w_step) ? '0 : (r_level - w_step[WIDTH-1:0]);
    assign w_do_inc  = tick && inc && !dec;
    assign w_do_dec  = tick && dec && !inc;

    // Band edges are multiples of a quarter of full scale.
    assign w_up_thr  = {({1'b0, r_band} + 3'd1), {(WIDTH-2){1'b0}}};
    assign w_dn_thr  = {1'b0, r_band, {(WIDTH-2){1'b0}}};
    // level < edge - HYST rewritten as level + HYST < edge to stay unsigned.
    assign w_band_up = (r_band != B3) && (w_level_x >= w_up_thr);
    assign w_band_dn = (r_band != B0) && ((w_level_x + HYST_X) < w_dn_thr);

`ifdef NT_DECAY_EN
    localparam int CNT_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY_TICKS - 1);

    logic [CNT_W-1:0] r_decay_cnt;
    logic             w_idle_tick;
    logic             w_cnt_last;

    assign w_idle_tick  = tick && !(inc ^ dec);
    assign w_cnt_last   = (r_decay_cnt == CNT_LAST);
    assign w_decay_step = w_idle_tick && w_cnt_last && (r_level != BASE_W);

    // Counter parks at its last value while the level already sits at baseline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_decay_cnt <= '0;
        end else if (tick) begin
            if (inc ^ dec) begin
                r_decay_cnt <= '0;
            end else if (w_cnt_last) begin
                r_decay_cnt <= (r_level != BASE_W) ? '0 : r_decay_cnt;
            end else begin
                r_decay_cnt <= r_decay_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign w_decay_step = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= BASE_W;
        end else if (w_do_inc) begin
            r_level <= w_inc_val;
        end else if (w_do_dec) begin
            r_level <= w_dec_val;
        end else if (w_decay_step) begin
            r_level <= (r_level > BASE_W) ? (r_level - WIDTH'(1)) : (r_level + WIDTH'(1));
        end
    end

    // Band FSM runs every cycle so it catches up one band per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_band <= BAND_RST;
        end else begin
            case (r_band)
                B0:      r_band <= w_band_up ? B1 : B0;
                B1:      r_band <= w_band_up ? B2 : (w_band_dn ? B0 : B1);
                B2:      r_band <= w_band_up ? B3 : (w_band_dn ? B1 : B2);
                B3:      r_band <= w_band_dn ? B2 : B3;
                default: r_band <= BAND_RST;
            endcase
        end
    end

    assign level   = r_level;
    assign level_q = r_band;
    assign sat_hi  = (w_level_x == MAX_X);
    assign sat_lo  = (r_level == '0);

endmodule
